// File: rtl/fwd_ctrl.sv
// Forwarding/hazard control for the 16-bit MIPS pipeline: EX-stage operand selects
// and load-use stall. Optional perf counters behind macro FWD_PERF_EN.
module fwd_ctrl #(
  parameter int REG_AW       = 3,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  output logic              stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef FWD_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       fwd_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } sb_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  sb_t        ex_q, ex_d, mem_q, mem_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [1:0] sel_a, sel_b;
  logic       ex_wr, mem_wr, hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b, id_live;

  function automatic logic is_writer(input sb_t e);
    return e.valid & e.regwrite & (!R0_HARDWIRED || (e.rd != '0));
  endfunction

  always_comb begin
    ex_wr     = is_writer(ex_q);
    mem_wr    = is_writer(mem_q);
    hit_ex_a  = id_uses_rs & ex_wr  & (ex_q.rd  == id_rs);
    hit_ex_b  = id_uses_rt & ex_wr  & (ex_q.rd  == id_rt);
    hit_mem_a = id_uses_rs & mem_wr & (mem_q.rd == id_rs);
    hit_mem_b = id_uses_rt & mem_wr & (mem_q.rd == id_rt);
    stall     = id_valid & ~flush & ex_wr & ex_q.memread & (hit_ex_a | hit_ex_b);
    id_live   = id_valid & ~flush & ~stall;
    // Nearer producer (EX) wins over MEM.
    sel_a     = hit_ex_a ? SEL_ALU : (hit_mem_a ? SEL_MEM : SEL_RF);
    sel_b     = hit_ex_b ? SEL_ALU : (hit_mem_b ? SEL_MEM : SEL_RF);

    ex_d    = ex_q;
    mem_d   = mem_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (!hold) begin
      mem_d   = ex_q;
      ex_d    = '{valid: id_live, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
      fwd_a_d = id_live ? sel_a : SEL_RF;
      fwd_b_d = id_live ? sel_b : SEL_RF;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef FWD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && !hold && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (!hold && ((fwd_a_d != SEL_RF) || (fwd_b_d != SEL_RF)) && fwd_cnt_q != 16'hFFFF)
      fwd_cnt_d = fwd_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: expected selects queued per issued instruction,
// popped after the edge; stall checked combinationally before the edge.
module tb_fwd_ctrl;
  logic       clock = 1'b0;
  logic       reset_n, hold, flush, id_valid;
  logic [2:0] id_rs, id_rt, id_rd;
  logic       id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic       stall;
  logic [1:0] fwd_a, fwd_b;
`ifdef FWD_PERF_EN
  logic [15:0] stall_cnt, fwd_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  fwd_ctrl #(.REG_AW(3), .R0_HARDWIRED(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef FWD_PERF_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

  // Present one ID instruction, check stall before the edge, fwd_* after it.
  task automatic issue(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                       input logic urs, input logic urt, input logic [2:0] rd,
                       input logic rw, input logic mr, input logic exp_st,
                       input logic [1:0] ea, input logic [1:0] eb, input string nm);
    logic [3:0] e;
    @(negedge clock);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
    #1;
    total++;
    if (stall !== exp_st) begin
      bad++;
      $display("FAIL %s stall: got %b want %b", nm, stall, exp_st);
    end
    exp_q.push_back({ea, eb});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    total++;
    if ({fwd_a, fwd_b} !== e) begin
      bad++;
      $display("FAIL %s fwd: got a=%b b=%b want a=%b b=%b", nm, fwd_a, fwd_b, e[3:2], e[1:0]);
    end
  endtask

  task automatic bubble(input string nm);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, nm);
  endtask

  task automatic drain();
    bubble("drain0");
    bubble("drain1");
  endtask

  task automatic test_reset();
    reset_n = 0; hold = 0; flush = 0;
    bubble("reset0");
    bubble("reset1");
    reset_n = 1;
`ifdef FWD_PERF_EN
    total++;
    if (stall_cnt !== 16'd0 || fwd_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, fwd_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    drain();
    issue(1, 2, 3, 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, "b2b_prod");
    issue(1, 1, 4, 1, 1, 5, 1, 0, 0, 2'b01, 2'b00, "b2b_cons");
  endtask

  task automatic test_distance2();
    drain();
    issue(1, 2, 3, 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, "d2_prod");
    issue(1, 5, 6, 1, 1, 7, 1, 0, 0, 2'b00, 2'b00, "d2_indep");
    issue(1, 2, 1, 1, 1, 3, 1, 0, 0, 2'b00, 2'b10, "d2_cons");
  endtask

  task automatic test_double();
    drain();
    issue(1, 1, 1, 1, 1, 2, 1, 0, 0, 2'b00, 2'b00, "dbl_p1");
    issue(1, 5, 6, 1, 1, 2, 1, 0, 0, 2'b00, 2'b00, "dbl_p2");
    issue(1, 2, 2, 1, 1, 4, 1, 0, 0, 2'b01, 2'b01, "dbl_cons");
  endtask

  task automatic test_load_use();
    drain();
    issue(1, 1, 0, 1, 0, 3, 1, 1, 0, 2'b00, 2'b00, "lu_load");
    issue(1, 3, 5, 1, 1, 6, 1, 0, 1, 2'b00, 2'b00, "lu_stall");
    issue(1, 3, 5, 1, 1, 6, 1, 0, 0, 2'b10, 2'b00, "lu_retry");
`ifdef FWD_PERF_EN
    total++;
    if (stall_cnt !== 16'd1) begin
      bad++;
      $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt);
    end
    total++;
    if (fwd_cnt !== 16'd4) begin
      bad++;
      $display("FAIL lu_fwd_cnt: got %0d want 4", fwd_cnt);
    end
`endif
  endtask

  task automatic test_r0_unused();
    drain();
    issue(1, 1, 2, 1, 1, 0, 1, 0, 0, 2'b00, 2'b00, "r0_prod");
    issue(1, 0, 0, 1, 1, 5, 1, 0, 0, 2'b00, 2'b00, "r0_cons");
    issue(1, 1, 2, 1, 1, 0, 1, 1, 0, 2'b00, 2'b00, "r0_load");
    issue(1, 0, 6, 1, 0, 5, 1, 0, 0, 2'b00, 2'b00, "r0_lcons");
    drain();
    issue(1, 1, 2, 1, 0, 4, 1, 1, 0, 2'b00, 2'b00, "nrt_load");
    issue(1, 6, 4, 1, 0, 5, 1, 0, 0, 2'b00, 2'b00, "nrt_cons");
  endtask

  task automatic test_flush();
    drain();
    issue(1, 1, 2, 1, 0, 3, 1, 1, 0, 2'b00, 2'b00, "fl_load");
    flush = 1;
    issue(1, 3, 3, 1, 1, 3, 1, 0, 0, 2'b00, 2'b00, "fl_squash");
    flush = 0;
    issue(1, 3, 3, 1, 1, 5, 1, 0, 0, 2'b10, 2'b10, "fl_after");
  endtask

  task automatic test_hold();
    drain();
    issue(1, 1, 1, 1, 1, 2, 1, 0, 0, 2'b00, 2'b00, "hd_alu");
    issue(1, 2, 0, 1, 0, 3, 1, 1, 0, 2'b01, 2'b00, "hd_load");
    hold = 1;
    for (int i = 0; i < 3; i++)
      issue(1, 3, 1, 1, 1, 5, 1, 0, 1, 2'b01, 2'b00, $sformatf("hd_frozen%0d", i));
    hold = 0;
    issue(1, 3, 1, 1, 1, 5, 1, 0, 1, 2'b00, 2'b00, "hd_release");
    issue(1, 3, 1, 1, 1, 5, 1, 0, 0, 2'b10, 2'b00, "hd_retry");
`ifdef FWD_PERF_EN
    total++;
    if (stall_cnt !== 16'd2) begin
      bad++;
      $display("FAIL hd_stall_cnt: got %0d want 2", stall_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    drain();
    issue(1, 1, 0, 1, 0, 3, 1, 1, 0, 2'b00, 2'b00, "rm_load");
    reset_n = 0;
    issue(1, 3, 3, 1, 1, 4, 1, 0, 1, 2'b00, 2'b00, "rm_reset");
    reset_n = 1;
    issue(1, 3, 3, 1, 1, 4, 1, 0, 0, 2'b00, 2'b00, "rm_after");
`ifdef FWD_PERF_EN
    total++;
    if (stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL rm_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
  endtask

  initial begin
    reset_n = 0; hold = 0; flush = 0; id_valid = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_regwrite = 0; id_memread = 0;
    test_reset();
    test_back_to_back();
    test_distance2();
    test_double();
    test_load_use();
    test_r0_unused();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
